// File: rtl/spi_flash_bridge_if.sv
// Sysbus-side signals of spi_flash_bridge: the master drives address and write strobe,
// the bridge returns data, its data-bus enable and ready.
interface spi_flash_bridge_if;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  q;
  logic        drive;
  logic        rdy;

  modport master (output addr, we, input q, drive, rdy);
  modport slave  (input addr, we, output q, drive, rdy);
endinterface

// File: rtl/spi_flash_bridge.sv
// Read-only sysbus window onto an SPI NOR flash (READ 0x03, mode 0) with a one-byte hit register.
// Define SPI_FLASH_STREAM_EN to keep CS asserted and continue sequential reads without a new command.
module spi_flash_bridge #(
  parameter logic [15:0] BASE         = 16'h8000,
  parameter logic [15:0] SIZE         = 16'h4000,
  parameter logic [23:0] FLASH_OFFSET = 24'h000000,
  parameter int unsigned SCK_DIV      = 1
) (
  input  logic                clk,
  input  logic                reset,
  spi_flash_bridge_if.slave   bus,
  output logic                spi_cs_n,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    DONE
`ifdef SPI_FLASH_STREAM_EN
    ,
    STREAM,
    GAP
`endif
  } state_t;

  localparam logic [8:0] DIV_LAST = 9'(SCK_DIV - 1);
`ifdef SPI_FLASH_STREAM_EN
  localparam logic [8:0] GAP_LAST = 9'(2 * SCK_DIV - 1);
`endif

  state_t      state;
  logic [15:0] lat_addr;
  logic [15:0] hit_addr;
  logic        hit_valid;
  logic [7:0]  q_r;
  logic [7:0]  sh_in;
  logic [31:0] sh_out;
  logic [5:0]  bit_cnt;
  logic [8:0]  cnt;
  logic        sel;
  logic        hit;
  logic        rd_miss;

  // 17-bit compare so a window ending at 16'hFFFF still decodes
  assign sel = ({1'b0, bus.addr} >= {1'b0, BASE}) &&
               ({1'b0, bus.addr} < ({1'b0, BASE} + {1'b0, SIZE}));
  assign hit       = hit_valid && (hit_addr == bus.addr);
  assign rd_miss   = sel && !bus.we && !hit;
  assign bus.drive = sel && !bus.we;
  assign bus.rdy   = reset || !sel || bus.we || hit;
  assign bus.q     = q_r;

  function automatic logic [31:0] cmd_frame(input logic [15:0] a);
    logic [15:0] off;
    logic [23:0] fa;
    off = a - BASE;
    fa  = FLASH_OFFSET + {8'h00, off};
    return {8'h03, fa};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      q_r       <= '0;
      hit_valid <= 1'b0;
      hit_addr  <= '0;
      lat_addr  <= '0;
      sh_out    <= '0;
      sh_in     <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_miss) begin
            lat_addr              <= bus.addr;
            {spi_mosi, sh_out}    <= {cmd_frame(bus.addr), 1'b0};
            bit_cnt               <= 6'd31;
            cnt                   <= DIV_LAST;
            spi_cs_n              <= 1'b0;
            state                 <= CMD;
          end
        end
        // Shared bit engine: low half then high half; MISO sampled as SCK rises,
        // MOSI advanced as SCK falls.
        CMD, DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 9'd1;
          end else begin
            cnt <= DIV_LAST;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              if (state == DATA) sh_in <= {sh_in[6:0], spi_miso};
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 6'd1;
                if (state == CMD) {spi_mosi, sh_out} <= {sh_out, 1'b0};
              end else if (state == CMD) begin
                bit_cnt  <= 6'd7;
                spi_mosi <= 1'b0;
                state    <= DATA;
              end else begin
                q_r       <= sh_in;
                hit_addr  <= lat_addr;
                hit_valid <= 1'b1;
                state     <= DONE;
              end
            end
          end
        end
        DONE: begin
`ifdef SPI_FLASH_STREAM_EN
          state <= STREAM;
`else
          spi_cs_n <= 1'b1;
          state    <= IDLE;
`endif
        end
`ifdef SPI_FLASH_STREAM_EN
        STREAM: begin
          if (rd_miss) begin
            lat_addr <= bus.addr;
            if ({1'b0, bus.addr} == ({1'b0, lat_addr} + 17'd1)) begin
              bit_cnt <= 6'd7;
              cnt     <= DIV_LAST;
              state   <= DATA;
            end else begin
              spi_cs_n <= 1'b1;
              cnt      <= GAP_LAST;
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 9'd1;
          end else begin
            {spi_mosi, sh_out} <= {cmd_frame(lat_addr), 1'b0};
            bit_cnt            <= 6'd31;
            cnt                <= DIV_LAST;
            spi_cs_n           <= 1'b0;
            state              <= CMD;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_bridge.sv
// Self-checking bench for spi_flash_bridge: SPI NOR flash model plus a transaction-level
// model of expected stalls, CS gaps, commands and data.
module tb_spi_flash_bridge;
  localparam int unsigned D       = 1;
  localparam int unsigned TIMEOUT = 400;
`ifdef SPI_FLASH_STREAM_EN
  localparam bit STREAM_EN = 1'b1;
`else
  localparam bit STREAM_EN = 1'b0;
`endif

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic spi_miso = 1'b0;
  logic spi_cs_n, spi_sck, spi_mosi;

  spi_flash_bridge_if bus_if ();

  spi_flash_bridge #(
    .BASE        (16'h8000),
    .SIZE        (16'h4000),
    .FLASH_OFFSET(24'h000000),
    .SCK_DIV     (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .spi_cs_n(spi_cs_n),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flash model: mode 0, shifts in 32 command/address bits, then streams bytes out.
  logic [7:0]  mem [0:16383];
  int unsigned fl_bits   = 0;
  int unsigned cmd_count = 0;
  int unsigned sck_rises = 0;
  logic [31:0] fl_cmd    = '0;
  logic [31:0] last_cmd  = '0;
  logic [23:0] fl_addr   = '0;
  logic [7:0]  fl_out    = '0;

  always @(posedge spi_sck) begin
    sck_rises++;
    if (!spi_cs_n) begin
      if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], spi_mosi};
      fl_bits++;
      if (fl_bits == 32) begin
        last_cmd = fl_cmd;
        fl_addr  = fl_cmd[23:0];
        cmd_count++;
      end
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_cs_n && fl_bits >= 32) begin
      if ((fl_bits - 32) % 8 == 0) begin
        fl_out = mem[fl_addr[13:0]];
        fl_addr++;
      end
      spi_miso = fl_out[7];
      fl_out   = {fl_out[6:0], 1'b0};
    end
  end

  always @(posedge spi_cs_n) begin
    fl_bits = 0;
    if (!reset) chk("cs_rise_sck_low", {31'd0, spi_sck}, 32'd0);
  end

  // Transaction-level expectation state
  logic        m_valid  = 1'b0;
  logic [15:0] m_addr   = '0;
  bit          m_stream = 1'b0;

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                          output int unsigned stall, output int unsigned csh, output logic drv);
    @(posedge clk);
    #1;
    bus_if.addr = a;
    bus_if.we   = 1'b0;
    stall = 0;
    csh   = 0;
    @(negedge clk);
    drv = bus_if.drive;
    while (bus_if.rdy !== 1'b1 && stall < TIMEOUT) begin
      stall++;
      if (spi_cs_n) csh++;
      @(negedge clk);
    end
    d = bus_if.q;
  endtask

  task automatic do_read(input logic [15:0] a);
    logic        hit, seq, drv;
    logic [7:0]  d;
    logic [15:0] off;
    int unsigned e_stall, e_csh, e_cmds, e_rises, s0, c0, stall, csh;
    hit = m_valid && (a == m_addr);
    seq = !hit && m_stream && (a == m_addr + 16'd1);
    if (hit)           begin e_stall = 0;                  e_csh = 0;     e_cmds = 0; e_rises = 0;  end
    else if (seq)      begin e_stall = 1 + 16 * D;         e_csh = 0;     e_cmds = 0; e_rises = 8;  end
    else if (m_stream) begin e_stall = 1 + 2 * D + 80 * D; e_csh = 2 * D; e_cmds = 1; e_rises = 40; end
    else               begin e_stall = 1 + 80 * D;         e_csh = 1;     e_cmds = 1; e_rises = 40; end
    off = a - 16'h8000;
    s0  = sck_rises;
    c0  = cmd_count;
    bus_read(a, d, stall, csh, drv);
    chk("rd_drive", {31'd0, drv}, 32'd1);
    chk("rd_stall", stall, e_stall);
    chk("rd_q", {24'd0, d}, {24'd0, mem[off[13:0]]});
    chk("rd_cs_high_cycles", csh, e_csh);
    chk("rd_cmd_count", cmd_count - c0, e_cmds);
    chk("rd_sck_rises", sck_rises - s0, e_rises);
    if (e_cmds == 1) chk("rd_cmd_word", last_cmd, {8'h03, 8'h00, off});
    if (!hit) begin
      m_valid  = 1'b1;
      m_addr   = a;
      m_stream = STREAM_EN;
    end
  endtask

  task automatic bus_write(input logic [15:0] a);
    int unsigned s0, c0;
    s0 = sck_rises;
    c0 = cmd_count;
    @(posedge clk);
    #1;
    bus_if.addr = a;
    bus_if.we   = 1'b1;
    @(negedge clk);
    chk("wr_rdy", {31'd0, bus_if.rdy}, 32'd1);
    chk("wr_drive", {31'd0, bus_if.drive}, 32'd0);
    @(posedge clk);
    #1;
    bus_if.we   = 1'b0;
    bus_if.addr = 16'h0000;
    repeat (2) @(negedge clk);
    chk("wr_no_sck", sck_rises - s0, 0);
    chk("wr_no_cmd", cmd_count - c0, 0);
  endtask

  task automatic oow(input logic [15:0] a);
    int unsigned s0;
    s0 = sck_rises;
    @(posedge clk);
    #1;
    bus_if.addr = a;
    bus_if.we   = 1'b0;
    @(negedge clk);
    chk("oow_drive", {31'd0, bus_if.drive}, 32'd0);
    repeat (3) @(negedge clk);
    chk("oow_no_sck", sck_rises - s0, 0);
  endtask

  initial begin : stim
    int unsigned s0, c0, r;
    logic [15:0] a;
    bus_if.addr = 16'h8010;
    bus_if.we   = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hA5;

    // Reset with a window read pending
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
      chk("rst_sck", {31'd0, spi_sck}, 32'd0);
      chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
      chk("rst_q", {24'd0, bus_if.q}, 32'd0);
      chk("rst_rdy", {31'd0, bus_if.rdy}, 32'd1);
    end
    reset       = 1'b0;
    bus_if.addr = 16'h0000;

    do_read(16'h8010);   // miss: 0x03000010, 81 stall cycles, q=A5
    do_read(16'h8010);   // hit
    bus_write(16'h8010);
    do_read(16'h8011);   // sequential
    do_read(16'h8100);   // broken stream
    oow(16'h7FFF);
    oow(16'hC000);

    // Request dropped mid-transfer still fills the hit register
    s0 = sck_rises;
    c0 = cmd_count;
    @(posedge clk);
    #1;
    bus_if.addr = 16'h8030;
    repeat (10) @(posedge clk);
    #1;
    bus_if.addr = 16'h0000;
    repeat (100) @(posedge clk);
    #1;
    chk("drop_sck_rises", sck_rises - s0, 40);
    chk("drop_cmd_count", cmd_count - c0, 1);
    chk("drop_cmd_word", last_cmd, 32'h0300_0030);
    m_valid  = 1'b1;
    m_addr   = 16'h8030;
    m_stream = STREAM_EN;
    do_read(16'h8030);

    do_read(16'h8000);
    do_read(16'hBFFF);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3 && m_valid && m_addr != 16'hBFFF) a = m_addr + 16'd1;
      else if (r < 5 && m_valid)                  a = m_addr;
      else if (r == 5) begin
        bus_write(16'h8000 + 16'($urandom_range(0, 16'h3FFF)));
        continue;
      end
      else a = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
      do_read(a);
    end

    // Reset in the middle of command bit 20
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus_if.addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    m_valid  = 1'b0;
    m_stream = 1'b0;
    @(posedge clk);
    #1;
    bus_if.addr = 16'h8020;
    repeat (41) @(posedge clk);
    #1;
    chk("mid_bits_sent", fl_bits, 20);
    chk("mid_stalled", {31'd0, bus_if.rdy}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("mid_rst_sck", {31'd0, spi_sck}, 32'd0);
    chk("mid_rst_q", {24'd0, bus_if.q}, 32'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus_if.addr = 16'h0000;
    do_read(16'h8010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_flash_bridge.md
# spi_flash_bridge

Read-only sysbus responder that maps an address window onto an external SPI NOR flash. It stalls the requesting master through `rdy` while it issues an SPI READ (0x03) transaction, then returns the fetched byte on the shared data bus. It sits beside the ROM and RAM responders on the arbitrated sysbus and drives the board `spi_*` pins.

## Interface
- `BASE`, 16'h8000: first bus address of the window.
- `SIZE`, 16'h4000: window length in bytes; the window is `BASE`..`BASE+SIZE-1`.
- `FLASH_OFFSET`, 24'h000000: flash byte address that corresponds to `BASE`.
- `SCK_DIV`, 1: SCK half-period in `clk` cycles; legal range 1..255.

Ports:
- `clk` in 1: system clock, the same clock as `sys.clk`.
- `reset` in 1: synchronous, active-high.
- `addr` in 16: sysbus address.
- `we` in 1: sysbus write strobe.
- `q` out 8: read data. The top level drives `sysbus.data` from `q` when `drive`=1.
- `drive` out 1: `sel & ~we`, where `sel` is the internal window decode.
- `rdy` out 1: bus ready. It is combinational and is valid only while `sel`=1; the top level tristates it otherwise.
- `spi_cs_n` out 1: flash chip select, active-low.
- `spi_sck` out 1: SPI clock, mode 0.
- `spi_mosi` out 1: command and address bits, MSB first.
- `spi_miso` in 1: flash data.

## Operation
- `sel = (addr >= BASE) && (addr < BASE+SIZE)`. Use 17-bit arithmetic so a window that ends at 16'hFFFF decodes correctly.
- Flash address: `FLASH_OFFSET + (addr - BASE)`, computed in 24 bits; wrap-around is permitted.
- Writes inside the window are ignored. `rdy`=1 and no state changes.
- Hit register: it holds `{valid, addr, byte}`. A read whose `addr` matches a valid entry is a hit: `rdy`=1 in the same cycle and `q` = the cached byte.
- A read miss stalls the master: `rdy`=0 until the DONE state.
- States:
  - IDLE: `spi_cs_n`=1, `spi_sck`=0. On a read miss, go to CMD and latch `addr`.
  - CMD: 32 bits are shifted out, {8'h03, 24-bit flash address}. Then go to DATA.
  - DATA: 8 bits are shifted in from `spi_miso`. Then go to DONE.
  - DONE: one cycle. Load the hit register, present `q`, `rdy`=1. Then go to IDLE, or to STREAM (see Configuration).
  - STREAM: `spi_cs_n` is held at 0.
    - A read of (last addr + 1) within the window goes to DATA directly.
    - Any other read miss goes to GAP.
    - A hit or an idle bus stays in STREAM.
  - GAP: `spi_cs_n`=1 for 2*`SCK_DIV` cycles, then go to CMD.
- Each bit: `spi_sck` is low for `SCK_DIV` cycles, then high for `SCK_DIV` cycles.
  - `spi_mosi` changes only while `spi_sck` is low.
  - `spi_miso` is sampled on the `clk` edge that raises `spi_sck`.
- If the master drops the request mid-transfer (`sel`=0), the transfer still completes and fills the hit register.
- Reset at any point: state goes to IDLE; `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `q`=8'h00, hit register invalid. Any flash transaction in progress is abandoned.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `q`=0, `rdy`=1.
- Miss from IDLE, with the request seen in cycle 0:
  - `spi_cs_n` falls at the end of cycle 0.
  - Bits occupy 80*`SCK_DIV` cycles.
  - DONE falls in cycle 1 + 80*`SCK_DIV`.
  - With `SCK_DIV`=1, `rdy` is low for cycles 0..80 and is 1 with valid `q` in cycle 81.
- Sequential stream hit: DONE in cycle 1 + 16*`SCK_DIV`.
- Broken stream: DONE in cycle 1 + 2*`SCK_DIV` + 80*`SCK_DIV`.
- Hits and writes: zero wait states.
- `spi_sck` ends low, and `spi_cs_n` rises only while `spi_sck`=0.

## Configuration
- `SPI_FLASH_STREAM_EN` defined: DONE goes to STREAM, and flash sequential-read continuation is used.
- Undefined: DONE goes to IDLE and `spi_cs_n` is released after every byte. Every miss costs the full 40-bit transaction, and the STREAM and GAP states do not exist.

## Test plan
- Reset: `reset`=1 for 2 cycles with `sel`=1 and `we`=0 → during reset `spi_cs_n`=1, `spi_sck`=0, `q`=0; after release the first read is a miss.
- Miss: `SCK_DIV`=1, flash model holding 8'hA5 at 0x000010, read 16'h8010 → MOSI carries 0x03_00_00_10; `rdy` is low for exactly 81 cycles; `q`=8'hA5 when `rdy` rises.
- Hit and write: re-read 16'h8010 → `rdy`=1 in the same cycle, `q`=8'hA5, no SCK toggles. Write 16'h8010 → `rdy`=1, no SPI activity.
- Sequential: read 16'h8010 then 16'h8011.
  - With the macro: the second read stalls 17 cycles, with no CS gap and no command.
  - Without the macro: `spi_cs_n` pulses high and the full 81-cycle stall repeats.
- Broken stream (macro on): read 16'h8010, then 16'h8100 → `spi_cs_n` is high for 2 cycles, then a new 0x03_00_01_00 command is sent.
- Reset mid-transfer: assert `reset` during bit 20 of CMD → next cycle `spi_cs_n`=1, `spi_sck`=0; the following read of 16'h8010 is a full miss.
